// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 widths, round-index type, forward S-box and Rcon shared by key and round logic.
package aes_pkg;
    localparam int AES_KEY_W = 128;
    localparam int AES_NR = 10;
    typedef logic [3:0] round_t;
    typedef enum logic {IDLE, EMIT} ks_state_e;
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction
    // Rounds 1..8 are successive powers of x; 9 and 10 wrap through the AES polynomial.
    function automatic logic [7:0] rcon(input round_t r);
        return (r >= 4'd1 && r <= 4'd8) ? 8'(8'h01 << (r - 4'd1)) :
               (r == 4'd9) ? 8'h1b : (r == 4'd10) ? 8'h36 : 8'h00;
    endfunction
endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// aes_inv_key_schedule_if: load request and round-key stream between key loader, schedule and consumer.
interface aes_inv_key_schedule_if;
    import aes_pkg::*;
    logic                 start;
    logic [AES_KEY_W-1:0] last_key;
    logic                 rk_ready;
    logic                 rk_valid;
    logic [AES_KEY_W-1:0] rk;
    round_t               rk_round;
    logic                 busy;
    logic                 done;
    modport master (output start, last_key, rk_ready, input rk_valid, rk, rk_round, busy, done);
    modport slave  (input start, last_key, rk_ready, output rk_valid, rk, rk_round, busy, done);
endinterface

// File: rtl/aes_sub_word.sv
// aes_sub_word: four parallel forward S-box lookups on a 32-bit word.
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] sub
);
    for (genvar i = 0; i < 4; i++) begin : g_sbox
        assign sub[8*i +: 8] = sbox(word[8*i +: 8]);
    end
endmodule

// File: rtl/aes_inv_key_schedule.sv
// aes_inv_key_schedule: walks AES-128 round keys from round 10 back to round 0, one per handshake,
// deriving each earlier key from the current one instead of storing the expanded schedule.
module aes_inv_key_schedule
    import aes_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    aes_inv_key_schedule_if.slave   bus
);
    ks_state_e            state;
    logic [AES_KEY_W-1:0] rk;
    round_t               rnd;
    logic                 valid;
    logic                 busy;
    logic                 done;
    logic [31:0]          p0, p1, p2, p3, sw;
    // Undo the forward XOR chain first; the recovered w3 feeds SubWord for the earlier w0.
    assign p3 = rk[127:96] ^ rk[95:64];
    assign p2 = rk[95:64] ^ rk[63:32];
    assign p1 = rk[63:32] ^ rk[31:0];
    aes_sub_word u_sub_word (.word({p3[7:0], p3[31:8]}), .sub(sw));
    assign p0 = rk[31:0] ^ sw ^ {24'h0, rcon(rnd)};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rk    <= '0;
            rnd   <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    rk    <= bus.last_key;
                    rnd   <= round_t'(AES_NR);
                    valid <= 1'b1;
                    busy  <= 1'b1;
                    state <= EMIT;
                end
                EMIT: if (bus.rk_ready) begin
                    if (rnd == '0) begin
                        valid <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        rk  <= {p3, p2, p1, p0};
                        rnd <= rnd - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.rk_valid = valid;
    assign bus.rk       = rk;
    assign bus.rk_round = rnd;
    assign bus.busy     = busy;
    assign bus.done     = done;
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// tb_aes_inv_key_schedule: forward-expansion scoreboard checks of the inverse key stream,
// plus FIPS-197 vectors, backpressure, ignored starts and mid-run reset.
module tb_aes_inv_key_schedule;
    import aes_pkg::*;
    typedef struct { logic [127:0] k; logic [3:0] r; } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int pass_cnt = 0;
    int total = 0;
    exp_t q[$];
    logic [127:0] obs [11];
    aes_inv_key_schedule_if bus ();
    aes_inv_key_schedule dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [127:0] bswap(input logic [127:0] x);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = x[8*(15-i) +: 8];
        return o;
    endfunction

    function automatic logic [7:0] tb_rcon(input int r);
        logic [7:0] t [11] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        return t[r];
    endfunction

    // Forward expansion: round i from round i-1, independent of the design's inverse direction.
    function automatic void expand(input logic [127:0] k0, output logic [127:0] ks [11]);
        logic [31:0] w [4];
        logic [31:0] t;
        for (int j = 0; j < 4; j++) w[j] = k0[32*j +: 32];
        ks[0] = k0;
        for (int i = 1; i <= 10; i++) begin
            t = {w[3][7:0], w[3][31:8]};
            for (int b = 0; b < 4; b++) t[8*b +: 8] = sbox(t[8*b +: 8]);
            w[0] = w[0] ^ t ^ {24'h0, tb_rcon(i)};
            w[1] = w[1] ^ w[0];
            w[2] = w[2] ^ w[1];
            w[3] = w[3] ^ w[2];
            ks[i] = {w[3], w[2], w[1], w[0]};
        end
    endfunction

    task automatic run_keys(input logic [127:0] k0, input bit rand_ready, input bit poke);
        logic [127:0] ks [11];
        int hs = 0;
        int cyc = 0;
        expand(k0, ks);
        q.delete();
        for (int i = 10; i >= 0; i--) q.push_back('{k: ks[i], r: 4'(i)});
        @(negedge clk);
        bus.start = 1'b1;
        bus.last_key = ks[10];
        bus.rk_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.last_key = ~ks[10];
        while (hs < 11 && cyc < 300) begin
            total++; if (bus.rk_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) $display("FAIL active_flags valid=%b busy=%b done=%b want 1 1 0", bus.rk_valid, bus.busy, bus.done); else pass_cnt++;
            total++; if (bus.rk !== q[0].k) $display("FAIL rk round %0d got %h want %h", q[0].r, bus.rk, q[0].k); else pass_cnt++;
            total++; if (bus.rk_round !== q[0].r) $display("FAIL rk_round got %0d want %0d", bus.rk_round, q[0].r); else pass_cnt++;
            bus.rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.start = poke && (bus.rk_round == 4'd7 || bus.rk_round == 4'd0);
            bus.last_key = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
            if (bus.rk_valid && bus.rk_ready) begin
                obs[q[0].r] = bus.rk;
                void'(q.pop_front());
                hs++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        bus.rk_ready = 1'b0;
        total++; if (hs !== 11) $display("FAIL handshakes got %0d want 11 (cycle budget)", hs); else pass_cnt++;
        total++; if (bus.done !== 1'b1 || bus.rk_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL end_flags done=%b valid=%b busy=%b want 1 0 0", bus.done, bus.rk_valid, bus.busy); else pass_cnt++;
        total++; if (bus.rk !== ks[0] || bus.rk_round !== 4'd0) $display("FAIL end_hold rk=%h rnd=%0d want %h 0", bus.rk, bus.rk_round, ks[0]); else pass_cnt++;
        @(negedge clk);
        total++; if (bus.done !== 1'b0 || bus.rk_valid !== 1'b0) $display("FAIL done_pulse done=%b valid=%b want 0 0", bus.done, bus.rk_valid); else pass_cnt++;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.rk_ready = 1'b0;
        bus.last_key = '0;
        repeat (5) @(negedge clk);
        total++; if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL reset_flags valid=%b busy=%b done=%b want 0 0 0", bus.rk_valid, bus.busy, bus.done); else pass_cnt++;
        total++; if (bus.rk !== '0 || bus.rk_round !== 4'd0) $display("FAIL reset_rk rk=%h rnd=%0d want 0 0", bus.rk, bus.rk_round); else pass_cnt++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0) $display("FAIL idle valid=%b busy=%b want 0 0", bus.rk_valid, bus.busy); else pass_cnt++;
    endtask

    task automatic test_full_run;
        run_keys(bswap(128'h2b7e151628aed2a6abf7158809cf4f3c), 1'b0, 1'b0);
        total++; if (obs[10] !== bswap(128'hd014f9a8c9ee2589e13f0cc8b6630ca6)) $display("FAIL fips_r10 got %h", obs[10]); else pass_cnt++;
        total++; if (obs[9] !== bswap(128'hac7766f319fadc2128d12941575c006e)) $display("FAIL fips_r9 got %h", obs[9]); else pass_cnt++;
        total++; if (obs[1] !== bswap(128'ha0fafe1788542cb123a339392a6c7605)) $display("FAIL fips_r1 got %h", obs[1]); else pass_cnt++;
        total++; if (obs[0] !== bswap(128'h2b7e151628aed2a6abf7158809cf4f3c)) $display("FAIL fips_r0 got %h", obs[0]); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        run_keys(bswap(128'h2b7e151628aed2a6abf7158809cf4f3c), 1'b1, 1'b0);
    endtask

    task automatic test_start_while_busy;
        run_keys(bswap(128'h2b7e151628aed2a6abf7158809cf4f3c), 1'b0, 1'b1);
        run_keys(bswap(128'h000102030405060708090a0b0c0d0e0f), 1'b1, 1'b0);
    endtask

    task automatic test_mid_run_reset;
        int cyc = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.last_key = bswap(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        bus.rk_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (bus.rk_round !== 4'd5 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        total++; if (bus.rk_round !== 4'd5) $display("FAIL reach_round5 got %0d want 5", bus.rk_round); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.rk !== '0 || bus.rk_round !== 4'd0) $display("FAIL async_reset valid=%b busy=%b done=%b rk=%h rnd=%0d want all 0", bus.rk_valid, bus.busy, bus.done, bus.rk, bus.rk_round); else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.done !== 1'b0 || bus.rk_valid !== 1'b0) $display("FAIL post_reset done=%b valid=%b want 0 0", bus.done, bus.rk_valid); else pass_cnt++;
        run_keys(bswap(128'h2b7e151628aed2a6abf7158809cf4f3c), 1'b0, 1'b0);
    endtask

    task automatic test_zero_key;
        run_keys('0, 1'b0, 1'b0);
        total++; if (obs[10] !== bswap(128'hb4ef5bcb3e92e21123e951cf6f8f188e)) $display("FAIL zero_r10 got %h", obs[10]); else pass_cnt++;
        total++; if (obs[0] !== '0) $display("FAIL zero_r0 got %h want 0", obs[0]); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_backpressure();
        test_start_while_busy();
        test_mid_run_reset();
        test_zero_key();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
